// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared types and helpers for the request arbiter
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } arb_state_t;

    // Widest requester vector the index helper accepts; callers zero-extend into it.
    localparam int ARB_MAX_WIDTH = 64;

    // Binary position of the set bit in a one-hot (or all-zero) vector.
    function automatic int unsigned onehot_to_index(input logic [ARB_MAX_WIDTH-1:0] oht);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_WIDTH; i++) begin
            if (oht[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/priority_to_onehot.sv
// rtl/priority_to_onehot.sv - rightmost-set-bit one-hot selector
module priority_to_onehot #(
    parameter int WIDTH          = 8,
    parameter int IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] oht
);

    generate
        if (IMPLEMENTATION == 0) begin : g_adder
            // Two's complement isolates the lowest set bit.
            assign oht = req & (~req + WIDTH'(1));
        end else begin : g_loop
            logic found;
            // Scan from index 0 upward and keep only the first request seen.
            always_comb begin
                oht   = '0;
                found = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (req[i] && !found) begin
                        oht[i] = 1'b1;
                        found  = 1'b1;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - registered fixed/round-robin arbiter with burst locking
module round_robin_arbiter
    import arbiter_pkg::*;
#(
    parameter  int WIDTH          = 8,
    parameter  int MODE           = 1,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req_vld,
    input  logic [WIDTH-1:0]     req_lck,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    output logic [WIDTH-1:0]     gnt_oht,
    output logic [WIDTH_LOG-1:0] gnt_idx
);

    arb_state_t           state;
    logic [WIDTH-1:0]     msk;
    logic [WIDTH-1:0]     served_above;
    logic [WIDTH-1:0]     nxt_msk;
    logic [WIDTH-1:0]     arb_msk;
    logic [WIDTH-1:0]     req_masked;
    logic [WIDTH-1:0]     oht_masked;
    logic [WIDTH-1:0]     oht_raw;
    logic [WIDTH-1:0]     sel_oht;
    logic [WIDTH_LOG-1:0] sel_idx;
    logic                 xfer;
    logic                 own_lck;
    logic                 own_req;
    logic                 any_req;
    logic                 release_xfer;
    logic                 rearb;

    assign xfer         = gnt_vld & gnt_rdy;
    assign own_lck      = |(req_lck & gnt_oht);
    assign own_req      = |(req_vld & gnt_oht);
    assign any_req      = |req_vld;
    assign release_xfer = xfer & ~own_lck;

    // Thermometer of positions strictly above the current grant; empty after the top index.
    always_comb begin
        logic acc;
        served_above = '0;
        acc          = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            served_above[i] = acc;
            acc             = acc | gnt_oht[i];
        end
    end

    // Fixed-priority mode never rotates, so its mask stays empty.
    assign nxt_msk    = (MODE == 1) ? served_above : '0;
    // A releasing transfer arbitrates with the rotated mask in the same cycle.
    assign arb_msk    = release_xfer ? nxt_msk : msk;
    assign req_masked = req_vld & arb_msk;

    priority_to_onehot #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_sel_masked (
        .req (req_masked),
        .oht (oht_masked)
    );

    priority_to_onehot #(
        .WIDTH          (WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_sel_raw (
        .req (req_vld),
        .oht (oht_raw)
    );

    assign sel_oht = (|req_masked) ? oht_masked : oht_raw;
    assign sel_idx = WIDTH_LOG'(onehot_to_index(ARB_MAX_WIDTH'(sel_oht)));

    // Load a fresh selection from idle, after a releasing transfer, or on owner withdrawal.
    assign rearb = (state == IDLE)
                 || ((state == GRANT) && (xfer ? !own_lck : !own_req))
                 || ((state == LOCK) && release_xfer);

    // Grant state machine with registered outputs and rotating priority mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            gnt_oht <= '0;
            gnt_idx <= '0;
            msk     <= '0;
        end else begin
            if (release_xfer) begin
                msk <= nxt_msk;
            end
            if (rearb) begin
                if (any_req) begin
                    state   <= GRANT;
                    gnt_vld <= 1'b1;
                    gnt_oht <= sel_oht;
                    gnt_idx <= sel_idx;
                end else begin
                    state   <= IDLE;
                    gnt_vld <= 1'b0;
                    gnt_oht <= '0;
                    gnt_idx <= '0;
                end
            end else if ((state == GRANT) && xfer) begin
                state <= LOCK;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb/tb_round_robin_arbiter.sv - scoreboard bench for round_robin_arbiter
module tb_round_robin_arbiter;

    localparam int W = 4;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic [W-1:0] req_vld = '0;
    logic [W-1:0] req_lck = '0;
    logic         gnt_rdy = 1'b0;

    logic         rr_vld;
    logic [W-1:0] rr_oht;
    logic [1:0]   rr_idx;
    logic         fp_vld;
    logic [W-1:0] fp_oht;
    logic [1:0]   fp_idx;

    always #5 clk = ~clk;

    round_robin_arbiter #(.WIDTH(W), .MODE(1), .IMPLEMENTATION(0)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_lck (req_lck),
        .gnt_vld (rr_vld),
        .gnt_rdy (gnt_rdy),
        .gnt_oht (rr_oht),
        .gnt_idx (rr_idx)
    );

    round_robin_arbiter #(.WIDTH(W), .MODE(0), .IMPLEMENTATION(1)) u_fp (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_vld (req_vld),
        .req_lck (req_lck),
        .gnt_vld (fp_vld),
        .gnt_rdy (gnt_rdy),
        .gnt_oht (fp_oht),
        .gnt_idx (fp_idx)
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] o;
        logic [1:0]   i;
    } gnt_t;

    gnt_t rr_q[$];
    gnt_t fp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: index 0 is the round-robin DUT, index 1 the fixed-priority DUT.
    int m_busy[2];
    int m_owner[2];
    int m_locked[2];
    int m_last[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin searches upward from just past the last served requester, then wraps.
    function automatic int pick(input logic [W-1:0] req, input int last, input bit rr);
        if (rr) begin
            for (int i = last + 1; i < W; i++) if (req[i]) return i;
        end
        for (int i = 0; i < W; i++) if (req[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_owner[m] = 0; m_locked[m] = 0; m_last[m] = -1;
        end
    endtask

    task automatic model_step(input int m, input logic [W-1:0] req,
                              input logic [W-1:0] lck, input logic rdy);
        bit rearb;
        int o;
        rearb = 0;
        if (m_busy[m] == 0) begin
            rearb = 1;
        end else if (m_locked[m] != 0) begin
            if (rdy && !lck[m_owner[m]]) begin
                m_last[m] = m_owner[m];
                rearb = 1;
            end
        end else if (rdy) begin
            if (lck[m_owner[m]]) m_locked[m] = 1;
            else begin
                m_last[m] = m_owner[m];
                rearb = 1;
            end
        end else if (!req[m_owner[m]]) begin
            rearb = 1;
        end
        if (rearb) begin
            o = pick(req, m_last[m], m == 0);
            m_busy[m]   = (o >= 0) ? 1 : 0;
            m_owner[m]  = (o >= 0) ? o : 0;
            m_locked[m] = 0;
        end
    endtask

    function automatic gnt_t model_out(input int m);
        gnt_t g;
        g.v = (m_busy[m] != 0);
        g.o = g.v ? (W'(1) << m_owner[m]) : '0;
        g.i = g.v ? 2'(m_owner[m]) : 2'd0;
        return g;
    endfunction

    // Drive one cycle of inputs after the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic r, input logic [W-1:0] req,
                        input logic [W-1:0] lck, input logic rdy);
        @(negedge clk);
        rst_n   = r;
        req_vld = req;
        req_lck = lck;
        gnt_rdy = rdy;
        if (!r) begin
            #1;
            check("rst_rr_vld", 32'(rr_vld), 32'(0));
            check("rst_rr_oht", 32'(rr_oht), 32'(0));
            check("rst_rr_idx", 32'(rr_idx), 32'(0));
            check("rst_fp_vld", 32'(fp_vld), 32'(0));
            model_reset();
        end else begin
            model_step(0, req, lck, rdy);
            model_step(1, req, lck, rdy);
        end
        rr_q.push_back(model_out(0));
        fp_q.push_back(model_out(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge, compare both DUTs against the oldest queued expectation.
    initial begin
        gnt_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rr_q.size() > 0) begin
                e = rr_q.pop_front();
                check("sb_rr_vld", 32'(rr_vld), 32'(e.v));
                check("sb_rr_oht", 32'(rr_oht), 32'(e.o));
                check("sb_rr_idx", 32'(rr_idx), 32'(e.i));
            end
            if (fp_q.size() > 0) begin
                e = fp_q.pop_front();
                check("sb_fp_vld", 32'(fp_vld), 32'(e.v));
                check("sb_fp_oht", 32'(fp_oht), 32'(e.o));
                check("sb_fp_idx", 32'(fp_idx), 32'(e.i));
            end
        end
    end

    initial begin
        logic [W-1:0] rq;
        logic [W-1:0] lk;
        logic         rd;
        logic         rs;
        model_reset();

        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        step(1, 4'b0000, 4'b0000, 0);

        // All requesting with ready held: rotation 0,1,2,3,0; fixed priority stays on 0.
        for (int k = 0; k < 5; k++) begin
            step(1, 4'b1111, 4'b0000, 1);
            settle();
            check("rr_rotate_idx", 32'(rr_idx), 32'(k % 4));
            check("fp_fixed_oht", 32'(fp_oht), 32'(4'b0001));
        end

        // Reset in the middle of traffic, then a lone top requester.
        step(0, 4'b1111, 4'b0000, 1);
        step(1, 4'b1000, 4'b0000, 0);
        settle();
        check("post_rst_idx", 32'(rr_idx), 32'(3));
        check("post_rst_vld", 32'(rr_vld), 32'(1));

        // Backpressure holds the grant, release moves on to requester 2.
        step(0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 4'b0101, 4'b0000, 0);
            settle();
            check("bp_hold_oht", 32'(rr_oht), 32'(4'b0001));
        end
        step(1, 4'b0101, 4'b0000, 1);
        settle();
        check("bp_next_oht", 32'(rr_oht), 32'(4'b0100));

        // Locked burst: three transfers on requester 0 including a bubble, then requester 1.
        step(0, 4'b0000, 4'b0000, 0);
        step(1, 4'b0011, 4'b0001, 0);
        settle();
        check("lck_first_oht", 32'(rr_oht), 32'(4'b0001));
        step(1, 4'b0011, 4'b0001, 1);
        settle();
        check("lck_hold1_oht", 32'(rr_oht), 32'(4'b0001));
        step(1, 4'b0010, 4'b0001, 0);
        settle();
        check("lck_bubble_oht", 32'(rr_oht), 32'(4'b0001));
        step(1, 4'b0010, 4'b0001, 1);
        settle();
        check("lck_hold2_oht", 32'(rr_oht), 32'(4'b0001));
        step(1, 4'b0010, 4'b0000, 1);
        settle();
        check("lck_release_oht", 32'(rr_oht), 32'(4'b0010));

        // Withdrawal re-arbitrates without a transfer.
        step(0, 4'b0000, 4'b0000, 0);
        step(1, 4'b0110, 4'b0000, 0);
        settle();
        check("wd_first_oht", 32'(rr_oht), 32'(4'b0010));
        step(1, 4'b0100, 4'b0000, 0);
        settle();
        check("wd_move_oht", 32'(rr_oht), 32'(4'b0100));
        step(1, 4'b0000, 4'b0000, 0);
        settle();
        check("wd_idle_vld", 32'(rr_vld), 32'(0));

        // Randomized traffic with occasional locks and resets.
        for (int n = 0; n < 600; n++) begin
            rq = W'($urandom_range(0, 15));
            lk = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : '0;
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 59) != 0);
            step(rs, rq, lk, rd);
        end

        step(1, 4'b0000, 4'b0000, 0);
        settle();
        check("queue_drained", 32'(rr_q.size() + fp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Registered request arbiter with a valid/ready grant handshake, selectable fixed-priority or round-robin policy, and per-requester grant locking for multi-transfer bursts. It generalises the combinational rightmost-priority one-hot selector into a stateful arbiter. It sits in front of any shared resource (bus master port, FIFO write side) with WIDTH competing requesters.

## Interface
- WIDTH, 8: number of requesters (≥2)
- WIDTH_LOG, $clog2(WIDTH): localparam, index width
- MODE, 1: 0 = fixed priority (index 0 highest), 1 = round-robin
- IMPLEMENTATION, 0: priority-selector implementation passed to sub-module (0 adder, 1 loop)

- clk  in  1  clock, one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req_vld  in  WIDTH  per-requester request
- req_lck  in  WIDTH  per-requester lock; sampled on that requester's transfer
- gnt_vld  out  1  grant valid
- gnt_rdy  in  1  downstream accepts granted transfer
- gnt_oht  out  WIDTH  one-hot granted requester (all zero when gnt_vld=0)
- gnt_idx  out  WIDTH_LOG  binary index of granted requester (0 when gnt_vld=0)

## Operation
- Transfer = gnt_vld & gnt_rdy.
- Priority mask msk (WIDTH bits, thermometer): positions above last served index. Selection: if (req_vld & msk) ≠ 0, rightmost set bit of (req_vld & msk); else rightmost set bit of req_vld. MODE=0: msk forced to 0 (rightmost of req_vld always).
- msk update (MODE=1 only) on every non-locked transfer by index k: msk = bits k+1..WIDTH-1 set; k=WIDTH-1 wraps to msk=0.
- States:
  - IDLE: gnt_vld=0. If any req_vld, load selection → GRANT.
  - GRANT: gnt_vld=1, gnt_oht/gnt_idx stable until transfer.
    - transfer & req_lck[idx]=1 → LOCK, same grant, msk unchanged.
    - transfer & req_lck[idx]=0 → update msk, re-arbitrate on current req_vld with new msk; any request → GRANT with new selection, else IDLE.
    - no transfer & req_vld[idx]=0 (withdrawal) → re-arbitrate on current req_vld with current msk (→ GRANT or IDLE).
  - LOCK: gnt_vld=1, same grant held even if req_vld[idx] drops (owner may bubble).
    - transfer & req_lck[idx]=0 → update msk, re-arbitrate as in GRANT.
    - otherwise stay.
- Back-to-back grants to different requesters with no idle cycle when gnt_rdy=1.
- gnt_oht always zero- or one-hot; gnt_idx always encodes gnt_oht.

## Timing
- All outputs registered. Reset (async assert, sync deassert by environment): state IDLE, gnt_vld=0, gnt_oht=0, gnt_idx=0, msk=0.
- Latency: req_vld rising in IDLE at cycle n → gnt_vld=1 at n+1.
- Re-arbitration after transfer or withdrawal at cycle n uses req_vld at n; new grant visible at n+1.
- gnt_rdy has no combinational path to gnt_* outputs; req_vld has none either.
- Reset mid-GRANT/LOCK: outputs clear immediately; lock and msk lost.
- Simultaneous events: transfer and req_vld[idx] dropping in same cycle counts as transfer (no withdrawal).

## Structure
- Package arbiter_pkg: state enum (IDLE, GRANT, LOCK), onehot-to-index function parametrised by width.
- Sub-module: two instances of priority_to_onehot (masked and unmasked request vectors), IMPLEMENTATION forwarded.

## Test plan
- Reset: assert rst_n=0 mid-traffic → gnt_vld=0, gnt_oht=0, gnt_idx=0 within the same cycle; after release req_vld=4'b1000 → gnt_idx=3 one cycle later.
- WIDTH=4, MODE=1, req_vld=4'b1111, gnt_rdy=1 → gnt_idx 0,1,2,3,0 on consecutive cycles, first grant one cycle after request.
- Backpressure: req_vld=4'b0101, gnt_rdy=0 three cycles → gnt_oht=4'b0001 stable; gnt_rdy=1 → next grant 4'b0100.
- Lock: req_vld=4'b0011, req_lck[0]=1 for two transfers then 0 → three transfers on 4'b0001, then 4'b0010; dropping req_vld[0] while in LOCK keeps gnt_oht=4'b0001.
- MODE=0, req_vld=4'b1111, gnt_rdy=1 → gnt_oht=4'b0001 every cycle.
- Withdrawal: req_vld=4'b0110 granted 4'b0010, gnt_rdy=0, drop req_vld[1] → next cycle gnt_oht=4'b0100; drop all → gnt_vld=0.
